dm_cache_ctrl: RTL and testbench

Controller for the direct-mapped cache. It sits between the CPU request port, the 8-entry cache data array and main memory. It keeps the tag and valid arrays, decides hit or miss, and drives the data array's read, write, address and data lines. The data array captures writes on the falling clk edge and registers read data on the rising edge. The cache is write-through and no-write-allocate.

---
 rtl/dm_cache_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Owns the tag and valid arrays, decides hit or miss, steers the external
// data array (falling-edge write, rising-edge registered read) and talks to
// main memory over a simple req/ack handshake. Keeps saturating hit and
// miss counters.
module dm_cache_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // CPU request port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              flush,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    // cache data array port
    output logic [IDX_W-1:0]  cm_addr,
    output logic              cm_rd,
    output logic              cm_wr,
    output logic [DATA_W-1:0] cm_wdata,
    input  logic [DATA_W-1:0] cm_rdata,
    // main memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // statistics
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_RD_WAIT,
        S_MEM_RD,
        S_FILL,
        S_MEM_WR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  fill_q, fill_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]   tag_q [LINES];
    logic [TAG_W-1:0]   tag_d;
    logic               tag_wr_en;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;

    // Split the latched request address into line index and tag
    assign req_idx = addr_q[IDX_W-1:0];
    assign req_tag = addr_q[ADDR_W-1:IDX_W];

    // A line hits only when it is valid and holds the requested tag
    assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign cpu_rdata = rdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    // Control state, request latches, valid bits and counters; reset aborts any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fill_q     <= '0;
            rdata_q    <= '0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fill_q     <= fill_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag array has no reset: a cleared valid bit makes stale tags harmless
    always_ff @(posedge clk) begin
        if (tag_wr_en) begin
            tag_q[req_idx] <= tag_d;
        end
    end

    // Next-state logic and register updates for each step of a transaction
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fill_d     = fill_q;
        rdata_d    = rdata_q;
        valid_d    = valid_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        tag_wr_en  = 1'b0;
        tag_d      = req_tag;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_TAG;
                end
            end
            S_TAG: begin
                if (hit) begin
                    if (hit_cnt_q != '1) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end
                if (we_q) begin
                    state_d = S_MEM_WR;
                end else if (hit) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_RD_WAIT: begin
                rdata_d = cm_rdata;
                state_d = S_DONE;
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    fill_d  = mem_rdata;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                tag_wr_en        = 1'b1;
                valid_d[req_idx] = 1'b1;
                rdata_d          = fill_q;
                state_d          = S_DONE;
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore decode of the data-array, memory and completion strobes
    always_comb begin
        cpu_ready = 1'b0;
        cm_addr   = '0;
        cm_rd     = 1'b0;
        cm_wr     = 1'b0;
        cm_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_TAG: begin
                if (hit) begin
                    cm_addr = req_idx;
                    if (we_q) begin
                        cm_wr    = 1'b1;
                        cm_wdata = wdata_q;
                    end else begin
                        cm_rd = 1'b1;
                    end
                end
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            S_FILL: begin
                cm_wr    = 1'b1;
                cm_addr  = req_idx;
                cm_wdata = fill_q;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            S_DONE: begin
                cpu_ready = 1'b1;
            end
            default: begin
                cpu_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Testbench for dm_cache_ctrl: models the data array and main memory,
// predicts each transaction from a line-level cache model and compares.
module tb_dm_cache_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              flush;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic [IDX_W-1:0]  cm_addr;
    logic              cm_rd;
    logic              cm_wr;
    logic [DATA_W-1:0] cm_wdata;
    logic [DATA_W-1:0] cm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // environment state
    logic [DATA_W-1:0] cm_array  [8];
    logic [DATA_W-1:0] mem_store [256];
    int                mem_delay = 0;
    int                wait_cnt  = 0;

    // reference model state
    bit                m_valid [8];
    logic [4:0]        m_tag   [8];
    logic [DATA_W-1:0] m_mem   [256];
    int                m_hits;
    int                m_misses;
    logic [DATA_W-1:0] m_last_rdata;

    dm_cache_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .flush    (flush),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .cm_addr  (cm_addr),
        .cm_rd    (cm_rd),
        .cm_wr    (cm_wr),
        .cm_wdata (cm_wdata),
        .cm_rdata (cm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data array: write on falling edge, registered read on rising edge
    always @(negedge clk) begin
        if (cm_wr === 1'b1) cm_array[cm_addr] <= cm_wdata;
    end

    always @(posedge clk) begin
        if (cm_rd === 1'b1) cm_rdata <= cm_array[cm_addr];
    end

    // Main memory: acknowledges after mem_delay extra cycles with a one-cycle pulse
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req === 1'b1 && rst === 1'b0) begin
                if (wait_cnt >= mem_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) mem_store[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_store[mem_addr];
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits       = 0;
        m_misses     = 0;
        m_last_rdata = '0;
    endtask

    // One CPU transaction, checked against the line-level model
    task automatic run_txn(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                           input int delay, input string name);
        logic [2:0]  idx;
        logic [4:0]  tg;
        bit          exp_hit;
        int          exp_lat;
        logic [7:0]  exp_rdata;
        int          lat;
        int          n_cm_wr;
        int          n_cm_rd;
        int          cm_rd_cyc;
        logic [2:0]  cm_wr_addr;
        logic [7:0]  cm_wr_data;
        logic [2:0]  cm_rd_addr;
        bit          saw_mem;
        bit          bad_mem;
        int          exp_cm_wr;
        logic [7:0]  exp_cm_data;

        idx       = addr[2:0];
        tg        = addr[7:3];
        exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
        exp_rdata = m_mem[addr];
        if (!we) exp_lat = exp_hit ? 3 : 3 + delay + 1;
        else     exp_lat = 2 + delay + 1;
        if (exp_hit) m_hits++;
        else         m_misses++;
        if (we) begin
            m_mem[addr] = wdata;
        end else begin
            m_last_rdata = exp_rdata;
            if (!exp_hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end
        exp_cm_wr   = (!we && !exp_hit) || (we && exp_hit) ? 1 : 0;
        exp_cm_data = we ? wdata : exp_rdata;

        n_cm_wr = 0; n_cm_rd = 0; cm_rd_cyc = 0;
        cm_wr_addr = '0; cm_wr_data = '0; cm_rd_addr = '0;
        saw_mem = 1'b0; bad_mem = 1'b0;

        mem_delay = delay;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (cpu_ready !== 1'b1 && lat < 60) begin
            if (mem_req === 1'b1) begin
                saw_mem = 1'b1;
                if (mem_we !== we || mem_addr !== addr) bad_mem = 1'b1;
                if (we && mem_wdata !== wdata) bad_mem = 1'b1;
            end
            if (cm_wr === 1'b1) begin
                n_cm_wr++;
                cm_wr_addr = cm_addr;
                cm_wr_data = cm_wdata;
            end
            if (cm_rd === 1'b1) begin
                n_cm_rd++;
                cm_rd_addr = cm_addr;
                cm_rd_cyc  = lat;
            end
            @(posedge clk); #1;
            lat++;
        end
        cpu_req = 1'b0;

        vectors++;
        if (cpu_ready !== 1'b1 || lat != exp_lat) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d (ready=%b), expected %0d", name, lat, cpu_ready, exp_lat);
        end
        vectors++;
        if (cpu_rdata !== m_last_rdata) begin
            miscompares++;
            $display("[TB] FAIL %s cpu_rdata: got %h, expected %h", name, cpu_rdata, m_last_rdata);
        end
        vectors++;
        if (saw_mem !== (we || !exp_hit) || bad_mem) begin
            miscompares++;
            $display("[TB] FAIL %s mem_req: seen=%b bad_fields=%b, expected seen=%b", name, saw_mem, bad_mem, we || !exp_hit);
        end
        vectors++;
        if (n_cm_wr != exp_cm_wr) begin
            miscompares++;
            $display("[TB] FAIL %s cm_wr count: got %0d, expected %0d", name, n_cm_wr, exp_cm_wr);
        end else if (exp_cm_wr == 1 && (cm_wr_addr !== idx || cm_wr_data !== exp_cm_data)) begin
            miscompares++;
            $display("[TB] FAIL %s cm_wr fields: got addr %0d data %h, expected addr %0d data %h",
                     name, cm_wr_addr, cm_wr_data, idx, exp_cm_data);
        end
        vectors++;
        if (n_cm_rd != ((!we && exp_hit) ? 1 : 0) ||
            (n_cm_rd == 1 && (cm_rd_addr !== idx || cm_rd_cyc != 1))) begin
            miscompares++;
            $display("[TB] FAIL %s cm_rd: got count %0d addr %0d cycle %0d, expected count %0d addr %0d cycle 1",
                     name, n_cm_rd, cm_rd_addr, cm_rd_cyc, (!we && exp_hit) ? 1 : 0, idx);
        end
        vectors++;
        if (hit_cnt !== CNT_W'(m_hits) || miss_cnt !== CNT_W'(m_misses)) begin
            miscompares++;
            $display("[TB] FAIL %s counters: got hit %0d miss %0d, expected hit %0d miss %0d",
                     name, hit_cnt, miss_cnt, m_hits, m_misses);
        end
        @(posedge clk); #1;
        vectors++;
        if (cpu_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s ready pulse width: got ready=%b a cycle later, expected 0", name, cpu_ready);
        end
    endtask

    // Pulse flush (optionally with a request) and confirm nothing is started
    task automatic pulse_flush(input bit with_req, input logic [7:0] addr, input string name);
        int activity;
        flush    = 1'b1;
        cpu_req  = with_req;
        cpu_we   = 1'b0;
        cpu_addr = addr;
        @(posedge clk); #1;
        flush   = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        activity = 0;
        for (int i = 0; i < 6; i++) begin
            if (cpu_ready !== 1'b0 || mem_req !== 1'b0 || cm_rd !== 1'b0 || cm_wr !== 1'b0) activity++;
            @(posedge clk); #1;
        end
        vectors++;
        if (activity != 0) begin
            miscompares++;
            $display("[TB] FAIL %s dropped request: got %0d active cycles, expected 0", name, activity);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({cpu_ready, cm_rd, cm_wr, mem_req, mem_we} !== 5'b0 ||
            cm_addr !== '0 || cm_wdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset strobes: got ready=%b cm_rd=%b cm_wr=%b mem_req=%b mem_we=%b, expected all 0",
                     cpu_ready, cm_rd, cm_wr, mem_req, mem_we);
        end
        vectors++;
        if (cpu_rdata !== '0 || hit_cnt !== '0 || miss_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset regs: got rdata=%h hit=%0d miss=%0d, expected 0/0/0", cpu_rdata, hit_cnt, miss_cnt);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_miss_fill();
        mem_store[8'h2A] = 8'h5C;
        m_mem[8'h2A]     = 8'h5C;
        run_txn(1'b0, 8'h2A, 8'h00, 2, "read_miss_2A");
    endtask

    task automatic test_read_hit();
        run_txn(1'b0, 8'h2A, 8'h00, 0, "read_hit_2A");
    endtask

    task automatic test_conflict();
        mem_store[8'h4A] = 8'h11;
        m_mem[8'h4A]     = 8'h11;
        run_txn(1'b0, 8'h4A, 8'h00, 1, "conflict_4A");
        run_txn(1'b0, 8'h2A, 8'h00, 0, "conflict_2A");
        vectors++;
        if (miss_cnt !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL conflict miss_cnt: got %0d, expected 3", miss_cnt);
        end
    endtask

    task automatic test_writes();
        run_txn(1'b0, 8'h4A, 8'h00, 0, "reload_4A");
        run_txn(1'b1, 8'h4A, 8'h77, 2, "write_hit_4A");
        run_txn(1'b0, 8'h4A, 8'h00, 0, "read_after_write_4A");
        run_txn(1'b1, 8'h13, 8'h99, 1, "write_miss_13");
        run_txn(1'b0, 8'h13, 8'h00, 0, "read_after_wmiss_13");
    endtask

    task automatic test_flush();
        pulse_flush(1'b1, 8'h4A, "flush_with_req");
        run_txn(1'b0, 8'h4A, 8'h00, 0, "read_after_flush_4A");
    endtask

    task automatic test_reset_abort();
        int cyc;
        int ready_seen;
        mem_delay = 20;
        cpu_we    = 1'b0;
        cpu_addr  = 8'h2A;
        cpu_req   = 1'b1;
        cyc = 0;
        @(posedge clk); #1;
        while (mem_req !== 1'b1 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort setup: got mem_req=%b, expected 1", mem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || cm_wr !== 1'b0 || cpu_ready !== 1'b0 ||
            hit_cnt !== '0 || miss_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort async: got mem_req=%b cm_wr=%b ready=%b hit=%0d miss=%0d, expected all 0",
                     mem_req, cm_wr, cpu_ready, hit_cnt, miss_cnt);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        ready_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_ready !== 1'b0 || mem_req !== 1'b0) ready_seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (ready_seen != 0) begin
            miscompares++;
            $display("[TB] FAIL abort quiet: got %0d active cycles, expected 0", ready_seen);
        end
        run_txn(1'b0, 8'h2A, 8'h00, 0, "read_after_reset_2A");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 8'h05, 8'hA5, 0, "b2b_w05");
        run_txn(1'b0, 8'h05, 8'h00, 0, "b2b_r05_miss");
        run_txn(1'b0, 8'h05, 8'h00, 0, "b2b_r05_hit");
        run_txn(1'b0, 8'hFD, 8'h00, 3, "b2b_rFD_conflict");
        run_txn(1'b0, 8'h05, 8'h00, 0, "b2b_r05_again");
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] d;
        bit         w;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                pulse_flush(1'b0, 8'h00, "rand_flush");
            end
            a = {3'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7))};
            d = 8'($urandom_range(0, 255));
            w = ($urandom_range(0, 2) == 0);
            run_txn(w, a, d, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        flush     = 1'b0;
        cm_rdata  = '0;
        for (int i = 0; i < 256; i++) begin
            mem_store[i] = 8'($urandom_range(0, 255));
            m_mem[i]     = mem_store[i];
        end
        for (int i = 0; i < 8; i++) begin
            cm_array[i] = '0;
            m_tag[i]    = '0;
        end
        model_reset();

        test_reset();
        test_miss_fill();
        test_read_hit();
        test_conflict();
        test_writes();
        test_flush();
        test_reset_abort();
        test_back_to_back();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
